// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end that shares one ALU_4_bit between
// two requesters. One transaction is in flight at a time: accept, drive the
// ALU operands, wait out the ALU latency, capture C, return it to the winner.
module alu_rr_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_opcode,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [4:0] rsp_data,
    output logic [1:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_c,
    output logic       busy
);

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic       grant;       // requester owning the in-flight transaction
    logic       last_grant;  // requester served most recently
    logic [2:0] cnt;         // remaining ALU latency edges
    logic       win;         // requester that would be accepted now
    logic       any_req;

    // Round-robin winner selection and the combinational accept strobe.
    always_comb begin
        win       = 1'b0;
        any_req   = |req_valid;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant;
            default: win = 1'b0;
        endcase
        if (state == IDLE && any_req) begin
            req_ready[win] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // Transaction sequencer: accept, wait out the ALU pipeline, hold the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 3'd0;
            alu_opcode <= 2'b00;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            rsp_data   <= 5'd0;
            rsp_valid  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_opcode <= win ? req_opcode[3:2] : req_opcode[1:0];
                        alu_a      <= win ? req_a[7:4] : req_a[3:0];
                        alu_b      <= win ? req_b[7:4] : req_b[3:0];
                        grant      <= win;
                        cnt        <= LAT;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        // C is passed through untouched; no sign or width change.
                        rsp_data  <= alu_c;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's rsp_ready can retire the response.
                    if (rsp_ready[grant]) begin
                        rsp_valid  <= 2'b00;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: an ALU_4_bit behavioural pipeline, table
// vectors, hand-written multi-cycle sequences and a randomized section
// checked against a transaction-level round-robin reference model.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [3:0] req_opcode = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic [4:0] rsp_data, alu_c;
    logic [1:0] alu_opcode;
    logic [3:0] alu_a, alu_b;
    logic       busy;

    logic [1:0] req_valid3 = '0, req_ready3, rsp_valid3, rsp_ready3 = '0;
    logic [3:0] req_opcode3 = '0;
    logic [7:0] req_a3 = '0, req_b3 = '0;
    logic [4:0] rsp_data3, alu_c3;
    logic [1:0] alu_opcode3;
    logic [3:0] alu_a3, alu_b3;
    logic       busy3;

    int checks = 0;
    int errors = 0;
    int m_last;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .busy(busy));

    alu_rr_arbiter #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_opcode(req_opcode3), .req_a(req_a3), .req_b(req_b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3),
        .busy(busy3));

    // ALU_4_bit behaviour: 4-bit two's complement operands, 5-bit result.
    function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] sa, sb;
        sa = {a[3], a};
        sb = {b[3], b};
        case (op)
            2'b00:   return sa + sb;
            2'b01:   return sa - sb;
            2'b10:   return ~sa;
            default: return {4'b0000, |b};
        endcase
    endfunction

    // ALU pipelines: latency 1 for dut, latency 3 for dut3.
    logic [4:0] p1;
    logic [4:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(alu_opcode, alu_a, alu_b);
        p3[0] <= alu_f(alu_opcode3, alu_a3, alu_b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign alu_c  = p1;
    assign alu_c3 = p3[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One transaction on dut (called at a negedge with dut idle).
    task automatic txn(input logic [1:0] v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int g, output logic [4:0] d, output int lat);
        req_valid = v; req_opcode = op; req_a = a; req_b = b; rsp_ready = 2'b11;
        #1;
        g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
        d = '0;
        lat = -1;
        if (g < 0) begin
            chk("req_ready_onehot", 32'(req_ready), 32'(v));
            req_valid = 2'b00;
            return;
        end
        @(negedge clk);
        req_valid = 2'b00;
        chk("busy_after_accept", 32'(busy), 1);
        lat = 0;
        while (rsp_valid == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_onehot", 32'(rsp_valid), (g == 1) ? 2 : 1);
        d = rsp_data;
        @(negedge clk);
        chk("busy_back_idle", 32'(busy), 0);
    endtask

    typedef struct {
        logic [1:0] v;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         g;
        logic [4:0] d;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int g, lat, w, n_acc, n_rsp, prev_cyc, exp_g, cyc;
        logic [4:0] d, exp_d;
        logic [1:0] v;
        logic [3:0] op;
        logic [7:0] a, b;

        tbl[0] = '{2'b01, 4'b0000, 8'h08, 8'h08, 0, 5'b10000};
        tbl[1] = '{2'b11, 4'b1001, 8'h07, 8'h08, 1, 5'b11111};
        tbl[2] = '{2'b11, 4'b1001, 8'h07, 8'h08, 0, 5'b01111};
        tbl[3] = '{2'b10, 4'b1100, 8'h00, 8'h40, 1, 5'b00001};
        tbl[4] = '{2'b01, 4'b0001, 8'h08, 8'h01, 0, 5'b10111};
        tbl[5] = '{2'b11, 4'b0010, 8'h75, 8'h70, 1, 5'b01110};
        tbl[6] = '{2'b11, 4'b0010, 8'h75, 8'h70, 0, 5'b11010};
        tbl[7] = '{2'b01, 4'b0011, 8'h00, 8'h00, 0, 5'b00000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b1;
        m_last = 1;
        @(negedge clk);

        // Table vectors
        foreach (tbl[i]) begin
            txn(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, g, d, lat);
            chk($sformatf("tbl%0d_grant", i), 32'(g), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_data", i), 32'(d), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 2);
            m_last = tbl[i].g;
        end

        // Randomized transactions against the round-robin reference
        for (int i = 0; i < 30; i++) begin
            v  = 2'($urandom_range(1, 3));
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            exp_g = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : 1 - m_last;
            w = exp_g;
            exp_d = alu_f(op[2*w +: 2], a[4*w +: 4], b[4*w +: 4]);
            txn(v, op, a, b, g, d, lat);
            chk("rand_grant", 32'(g), 32'(exp_g));
            chk("rand_data", 32'(d), 32'(exp_d));
            chk("rand_latency", 32'(lat), 2);
            m_last = exp_g;
        end

        // Both requesters continuously valid: strict alternation, spacing 4
        req_valid = 2'b11; req_opcode = 4'b1001; req_a = 8'h07; req_b = 8'h08; rsp_ready = 2'b11;
        #1;
        n_acc = 0; n_rsp = 0; prev_cyc = 0;
        for (cyc = 0; cyc < 24; cyc++) begin
            if (req_ready != 2'b00) begin
                exp_g = 1 - m_last;
                chk("alt_grant", 32'(req_ready), (exp_g == 1) ? 2 : 1);
                if (n_acc > 0) chk("alt_spacing", 32'(cyc - prev_cyc), 4);
                m_last = exp_g;
                prev_cyc = cyc;
                n_acc++;
            end
            if (rsp_valid != 2'b00) begin
                chk("alt_data", 32'(rsp_data), (rsp_valid == 2'b01) ? 32'h0f : 32'h1f);
                n_rsp++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("alt_accepts", 32'(n_acc), 6);
        chk("alt_responses", 32'(n_rsp), 6);
        chk("alt_idle", 32'(busy), 0);

        // Backpressure on requester 1; requester 0 waits until IDLE
        req_valid = 2'b10; req_opcode = 4'b1100; req_a = 8'h03; req_b = 8'h42; rsp_ready = 2'b01;
        #1;
        chk("bp_ready1", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 2'b01;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 20) begin
            chk("bp_ready_wait", 32'(req_ready), 0);
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 2);
            chk("bp_rsp_data", 32'(rsp_data), 1);
            chk("bp_ready_resp", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp_ready0_idle", 32'(req_ready), 1);
        m_last = 1;
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_req0_valid", 32'(rsp_valid), 1);
        chk("bp_req0_data", 32'(rsp_data), 5);
        @(negedge clk);
        m_last = 0;

        // Reset during WAIT restores last_grant to 1
        req_valid = 2'b01; req_opcode = 4'b0000; req_a = 8'h01; req_b = 8'h01;
        @(negedge clk);
        req_valid = 2'b00;
        chk("rw_busy_wait", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("rw_rsp_valid", 32'(rsp_valid), 0);
        chk("rw_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b11; req_opcode = 4'b0100; req_a = 8'h12; req_b = 8'h13; rsp_ready = 2'b11;
        #1;
        chk("rw_grant0", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rw_rsp", 32'({rsp_valid, rsp_data}), 32'({2'b01, 5'd5}));
        @(negedge clk);
        m_last = 0;

        // req_valid[0] pulse during RESP leaves no trace
        req_valid = 2'b10; req_opcode = 4'b1100; req_a = 8'h50; req_b = 8'h40; rsp_ready = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = 2'b01; req_opcode = 4'b1101; req_a = 8'h57; req_b = 8'h41;
        #1;
        chk("pulse_ready", 32'(req_ready), 0);
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b10;
        @(negedge clk);
        chk("pulse_idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("pulse_no_grant", 32'(busy), 0);
        chk("pulse_alu_ops", 32'({alu_opcode, alu_a, alu_b}), 32'({2'b11, 4'h5, 4'h4}));
        m_last = 1;

        // ALU_LATENCY = 3 instance
        for (int t = 0; t < 2; t++) begin
            a = (t == 0) ? 8'h07 : 8'h0f;
            b = 8'h07;
            op = (t == 0) ? 4'b0000 : 4'b0001;
            exp_d = (t == 0) ? 5'd14 : 5'b11000;
            req_valid3 = 2'b01; req_opcode3 = op; req_a3 = a; req_b3 = b; rsp_ready3 = 2'b01;
            #1;
            chk("l3_ready", 32'(req_ready3), 1);
            @(negedge clk);
            req_valid3 = 2'b00;
            lat = 0;
            while (rsp_valid3 == 2'b00 && lat < 20) begin
                chk("l3_alu_stable", 32'({alu_a3, alu_b3}), 32'({a[3:0], b[3:0]}));
                @(negedge clk);
                lat++;
            end
            chk("l3_latency", 32'(lat), 4);
            chk("l3_data", 32'(rsp_data3), 32'(exp_d));
            @(negedge clk);
            chk("l3_idle", 32'(busy3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one ALU_4_bit instance between two requesters (ports 0 and 1) using round-robin arbitration.
- Per request, the block:
  - accepts an opcode/A/B transaction over a valid/ready handshake;
  - drives the ALU operand inputs and waits out the ALU pipeline latency;
  - captures C and returns it to the winning requester over a valid/ready response.
- Sits between the ALU_4_bit datapath and its clients. Exactly one transaction is in flight at any time.

Parameters:
- ALU_LATENCY, 1, number of clk edges from the ALU sampling Opcode/A/B to C being valid (range 1..7).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accept; combinational.
- req_opcode  in  4  {op1[1:0], op0[1:0]}; encodings: 00 Add, 01 Sub, 10 Not_A, 11 ReductionOR_B.
- req_a  in  8  {a1, a0}, each 4-bit two's complement.
- req_b  in  8  {b1, b0}, each 4-bit two's complement.
- rsp_valid  out  2  per-requester response valid; at most one bit set.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  5  captured ALU result C, two's complement, shared by both requesters.
- alu_opcode  out  2  to ALU Opcode; registered.
- alu_a  out  4  to ALU A; registered.
- alu_b  out  4  to ALU B; registered.
- alu_c  in  5  from ALU C.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and any in-flight transaction is dropped.
  - Outputs: alu_opcode/a/b=0, rsp_data=0, rsp_valid=0, busy=0.
  - Internal state: last_grant=1, so requester 0 wins first; latency counter=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner selection:
    - if exactly one req_valid bit is set, that requester wins;
    - if both are set, the requester != last_grant wins.
  - req_ready[winner]=1 combinationally, only in IDLE and only when req_valid[winner]=1. The other ready bit is 0.
  - On the accepting edge (E0):
    - load the winner's op/a/b into alu_opcode/a/b;
    - store the grant id;
    - load cnt=ALU_LATENCY;
    - go to WAIT.
- WAIT:
  - alu_opcode/a/b hold stable. The ALU samples them at E1.
  - Each edge with cnt!=0 decrements cnt.
  - On the edge where cnt==0: rsp_data<=alu_c, go to RESP.
  - Result: rsp_valid rises after edge E0+ALU_LATENCY+1.
- RESP:
  - rsp_valid[grant]=1 and rsp_data is held until rsp_ready[grant]=1 at an edge.
  - On that edge: clear rsp_valid, set last_grant<=grant, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Turnaround:
  - No request is accepted in WAIT or RESP; req_ready=0 there.
  - Minimum spacing between accepts is ALU_LATENCY+3 cycles.
- A requester may drop req_valid before it is accepted, with no side effect. Payload must be stable while req_valid=1.
- alu_opcode/a/b keep the last transaction's values in IDLE; they are not cleared.
- Arithmetic: the block passes the 5-bit C through unmodified; no sign or width conversion.
- Starvation: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset asserted in WAIT or RESP: the transaction is lost with no response, and last_grant returns to 1.
- The ALU's own synchronous reset is not driven by this block.

Test Plan:
- After reset, req_valid=01, op=Add, a0=-8, b0=-8, rsp_ready=01 → req_ready=01 for one cycle; rsp_valid=01 after edge E0+2 with rsp_data=-16 (5'b10000); busy high from E0 until the IDLE return.
- Both requesters valid continuously; req0 Sub 7-(-8), req1 Not_A A=4'b0000, rsp_ready=11 → grant order 0,1,0,1; responses 15 (req0) and 5'b11111 (req1) alternate; accept spacing 4 cycles.
- req1 ReductionOR_B B=4'b0100, rsp_ready held 0 for 5 cycles → rsp_valid=10 and rsp_data=1 hold steady; req_valid[0] raised meanwhile gets req_ready=0 until the response completes, then is accepted in IDLE.
- ALU_LATENCY=3, req0 Add A=7, B=7 → alu_a/b stable through WAIT; rsp_valid after E0+4 with rsp_data=14; the block never samples alu_c early.
- reset pulsed low during WAIT → rsp_valid=0, busy=0 immediately; next simultaneous request (req_valid=11) is granted to requester 0.
- req_valid[0] pulsed while in RESP and dropped before IDLE → no grant or ALU operand change occurs for that pulse.
